// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target with synchronized pins, TX hold register and
//            RX FIFO with sticky overrun.
// Revision : 1.0
// ============================================================================
module spi_target #(
   parameter int         RX_DEPTH  = 4,
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] si,
   input  logic       we,
   output logic       wa,
   output logic [7:0] so,
   output logic       rv,
   input  logic       re,
   output logic       ov,
   input  logic       ov_clr,
   output logic       busy
);
   localparam int c_ADDR_W = $clog2(RX_DEPTH);

   logic [2:0]          r_sclk_sync;
   logic [2:0]          r_cs_sync;
   logic [1:0]          r_mosi_sync;
   logic [2:0]          r_bc;
   logic [6:0]          r_rxs;
   logic [7:0]          r_txs;
   logic [7:0]          r_hold;
   logic                r_hold_v;
   logic                r_reload;
   logic                r_ov;
   logic [c_ADDR_W:0]   r_wr_ptr;
   logic [c_ADDR_W:0]   r_rd_ptr;
   logic [7:0]          r_mem [RX_DEPTH];

   logic                w_active;
   logic                w_mosi;
   logic                w_bit_rise;
   logic                w_bit_fall;
   logic                w_cs_fall;
   logic                w_cs_rise;
   logic                w_byte_done;
   logic [7:0]          w_rx_byte;
   logic                w_tx_load;
   logic                w_we_acc;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push_ok;
   logic                w_overrun;

   assign w_active    = ~r_cs_sync[1];
   assign w_mosi      = r_mosi_sync[1];
   assign w_cs_fall   = ~r_cs_sync[1] &  r_cs_sync[2];
   assign w_cs_rise   =  r_cs_sync[1] & ~r_cs_sync[2];
   assign w_bit_rise  = w_active &  r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_bit_fall  = w_active & ~r_sclk_sync[1] &  r_sclk_sync[2];
   assign w_byte_done = w_bit_rise & (r_bc == 3'd7);
   // Eighth bit bypasses the shift register straight into the FIFO.
   assign w_rx_byte   = {r_rxs, w_mosi};

   assign w_tx_load   = w_cs_fall | (w_bit_fall & r_reload);
   assign w_we_acc    = we & (~r_hold_v | w_tx_load);

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                        (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
   assign w_pop       = re & ~w_empty;
   // A same-cycle pop frees the slot the push needs.
   assign w_push_ok   = w_byte_done & (~w_full | w_pop);
   assign w_overrun   = w_byte_done & w_full & ~w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= 3'b111;
         r_cs_sync   <= 3'b111;
         r_mosi_sync <= 2'b11;
         r_bc        <= 3'd0;
         r_rxs       <= 7'd0;
         r_txs       <= IDLE_BYTE;
         r_reload    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_cs_sync   <= {r_cs_sync[1:0], cs};
         r_mosi_sync <= {r_mosi_sync[0], mosi};

         if (w_cs_fall) begin
            r_bc     <= 3'd0;
            r_reload <= 1'b0;
         end else if (w_cs_rise) begin
            r_bc <= 3'd0;
         end else if (w_bit_rise) begin
            r_rxs <= w_rx_byte[6:0];
            r_bc  <= r_bc + 3'd1;
            if (r_bc == 3'd7) r_reload <= 1'b1;
         end else if (w_bit_fall && r_reload) begin
            r_reload <= 1'b0;
         end

         if (w_tx_load)
            r_txs <= r_hold_v ? r_hold : IDLE_BYTE;
         else if (w_bit_fall)
            r_txs <= {r_txs[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold   <= 8'h00;
         r_hold_v <= 1'b0;
      end else if (w_we_acc) begin
         r_hold   <= si;
         r_hold_v <= 1'b1;
      end else if (w_tx_load) begin
         r_hold_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ov     <= 1'b0;
      end else begin
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_overrun)   r_ov <= 1'b1;
         else if (ov_clr) r_ov <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_rx_byte;
   end

   assign miso = w_active ? r_txs[7] : 1'b1;
   assign wa   = r_hold_v;
   assign rv   = ~w_empty;
   assign so   = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
   assign ov   = r_ov;
   assign busy = w_active;
endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Brief    : Randomized and directed checks of spi_target against a
//            queue-based byte-level model.
// Revision : 1.0
// ============================================================================
module tb_spi_target;
   localparam int DEPTH = 4;

   logic       clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b1;
   logic       we = 1'b0, re = 1'b0, ov_clr = 1'b0;
   logic [7:0] si = 8'h00;
   logic       miso, wa, rv, ov, busy;
   logic [7:0] so;

   always #5 clk = ~clk;

   spi_target #(.RX_DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
      .si(si), .we(we), .wa(wa), .so(so), .rv(rv), .re(re), .ov(ov),
      .ov_clr(ov_clr), .busy(busy)
   );

   int vectors = 0, miscompares = 0;
   bit chk_en = 0;

   logic [7:0] q[$];
   logic [7:0] m_hold = 8'h00;
   bit         m_hold_v = 0;
   bit         m_ov = 0;
   logic [7:0] tx_mosi [0:3];
   logic [7:0] got [0:3];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Idle-time comparison against the byte-level model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rv", rv, q.size() != 0);
         check("so", so, (q.size() != 0) ? q[0] : 8'h00);
         check("ov", ov, m_ov);
         check("wa", wa, m_hold_v);
         check("busy", busy, 1'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hold(input logic [7:0] b);
      we = 1'b1; si = b;
      tick();
      we = 1'b0;
      if (!m_hold_v) begin
         m_hold   = b;
         m_hold_v = 1;
      end
   endtask

   task automatic pop();
      re = 1'b1;
      tick();
      re = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic clear_ov();
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      m_ov = 0;
   endtask

   // Master side: mode 0, sclk high/low 4 clk each, MSB first.
   task automatic xfer(input int nbits, input bit pop_last);
      logic [7:0] first, tbyte;
      logic       exp_bit;
      int         nfull;
      chk_en = 0;
      first = m_hold_v ? m_hold : 8'hFF;
      m_hold_v = 0;
      for (int i = 0; i < 4; i++) got[i] = 8'h00;
      cs = 1'b0;
      mosi = tx_mosi[0][7];
      repeat (6) tick();
      check("busy_active", busy, 1'b1);
      for (int k = 0; k < nbits; k++) begin
         tbyte   = (k < 8) ? first : 8'hFF;
         exp_bit = tbyte[7 - (k % 8)];
         got[k / 8] = {got[k / 8][6:0], miso};
         check("miso_bit", miso, exp_bit);
         sclk = 1'b1;
         if (pop_last && k == nbits - 1) begin
            tick(); tick();
            re = 1'b1;
            tick();
            re = 1'b0;
            tick();
         end else begin
            repeat (4) tick();
         end
         sclk = 1'b0;
         if (k + 1 < nbits) mosi = tx_mosi[(k + 1) / 8][7 - ((k + 1) % 8)];
         repeat (4) tick();
      end
      cs = 1'b1;
      mosi = 1'b1;
      repeat (6) tick();
      nfull = nbits / 8;
      for (int b = 0; b < nfull; b++) begin
         if (pop_last && b == nfull - 1 && q.size() != 0) void'(q.pop_front());
         if (q.size() < DEPTH) q.push_back(tx_mosi[b]);
         else m_ov = 1;
      end
      chk_en = 1;
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_miso", miso, 1'b1);
      check("rst_wa", wa, 1'b0);
      check("rst_rv", rv, 1'b0);
      check("rst_so", so, 8'h00);
      check("rst_ov", ov, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk_en = 1;

      // Preloaded hold A5, receive 3C.
      write_hold(8'hA5);
      check("t1_wa_set", wa, 1'b1);
      tx_mosi[0] = 8'h3C;
      xfer(8, 0);
      check("t1_master_rx", got[0], 8'hA5);
      check("t1_so", so, 8'h3C);
      check("t1_wa_clear", wa, 1'b0);
      pop();

      // Back-to-back bytes with empty hold.
      tx_mosi[0] = 8'h11; tx_mosi[1] = 8'h22;
      xfer(16, 0);
      check("t2_rx0", got[0], 8'hFF);
      check("t2_rx1", got[1], 8'hFF);
      check("t2_head0", so, 8'h11);
      pop();
      check("t2_head1", so, 8'h22);
      pop();
      check("t2_empty_so", so, 8'h00);
      check("t2_empty_rv", rv, 1'b0);

      // Overrun on fifth byte.
      for (int i = 1; i <= 5; i++) begin
         tx_mosi[0] = 8'(i);
         xfer(8, 0);
      end
      check("t3_ov", ov, 1'b1);
      clear_ov();
      check("t3_ov_clr", ov, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         check("t3_pop", so, i);
         pop();
      end

      // Abort after 5 bits, then 81.
      tx_mosi[0] = 8'hF0;
      xfer(5, 0);
      check("t4_nopush", rv, 1'b0);
      tx_mosi[0] = 8'h81;
      xfer(8, 0);
      check("t4_head", so, 8'h81);
      pop();

      // Push and pop in the same cycle on a full FIFO.
      for (int i = 0; i < 4; i++) begin
         tx_mosi[0] = 8'h0A + 8'(i);
         xfer(8, 0);
      end
      tx_mosi[0] = 8'h99;
      xfer(8, 1);
      check("t5_ov", ov, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("t5_order", so, (i == 3) ? 8'h99 : 8'h0B + 8'(i));
         pop();
      end

      // Randomized mix.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0: write_hold(8'($urandom));
            1: pop();
            2: clear_ov();
            3, 4: begin
               for (int i = 0; i < 4; i++) tx_mosi[i] = 8'($urandom);
               xfer(8 * $urandom_range(1, 3), 0);
            end
            default: begin
               for (int i = 0; i < 4; i++) tx_mosi[i] = 8'($urandom);
               xfer(8 * $urandom_range(0, 1) + $urandom_range(1, 7), 0);
            end
         endcase
         tick();
      end

      // Async reset mid-byte.
      write_hold(8'h33);
      tx_mosi[0] = 8'hC3;
      xfer(8, 0);
      write_hold(8'h44);
      chk_en = 0;
      cs = 1'b0;
      repeat (6) tick();
      for (int k = 0; k < 3; k++) begin
         sclk = 1'b1; repeat (4) tick();
         sclk = 1'b0; repeat (4) tick();
      end
      #3 rst = 1'b1;
      #1;
      check("arst_miso", miso, 1'b1);
      check("arst_wa", wa, 1'b0);
      check("arst_rv", rv, 1'b0);
      check("arst_so", so, 8'h00);
      check("arst_ov", ov, 1'b0);
      check("arst_busy", busy, 1'b0);
      cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
      q.delete();
      m_hold_v = 0;
      m_ov = 0;
      tick(); tick();
      rst = 1'b0;
      repeat (2) tick();
      chk_en = 1;
      write_hold(8'h5A);
      tx_mosi[0] = 8'h7E;
      xfer(8, 0);
      check("t6_master_rx", got[0], 8'h5A);
      check("t6_head", so, 8'h7E);
      repeat (4) tick();

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
